pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register, the successor to the fixed ID/EX latch. It carries a WIDTH-bit packed payload between two pipeline stages through a DEPTH-entry elastic buffer with a valid/ready handshake. It supports synchronous flush and a registered backpressure path. It replaces ad-hoc stall/flush latches between decode, execute and memory stages, so that a downstream stall no longer needs a combinational path to the upstream stage.

## Interface
Parameters:
- WIDTH, 256: payload bits per entry (packed pc, operands, immediates, control fields).
- DEPTH, 2: buffer entries; legal values are 1 to 8. DEPTH ≥ 2 is required for one transfer per cycle under backpressure.
- CNT_W, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  buffer accepts an entry this cycle.
- out_valid  out  1  head entry present.
- out_data  out  WIDTH  head payload.
- out_ready  in  1  downstream consumes the head this cycle.
- count  out  CNT_W  current occupancy, 0 to DEPTH.
- stall_cnt  out  32  backpressure cycle counter (see Configuration).
- bubble_cnt  out  32  starvation cycle counter (see Configuration).

## Operation
- The block is a circular FIFO with read pointer rp, write pointer wp (each 0..DEPTH-1, wrapping DEPTH-1→0) and count.
- in_ready = (count < DEPTH). It is decoded only from registered state and has no combinational dependence on out_ready.
- out_valid = (count != 0).
- out_data = mem[rp] when out_valid; out_data = all-zero when the buffer is empty.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- On push: mem[wp] ← in_data and wp advances. On pop: rp advances.
- count next value = count + push − pop. Push and pop in the same cycle leave count unchanged.
- When full, in_ready = 0, so no push occurs even if pop = 1 that cycle. DEPTH = 1 therefore sustains at most one transfer every 2 cycles.
- flush drops all entries: rp, wp and count go to 0, and every mem entry goes to zero. Any push or pop presented in the same cycle as flush is discarded.
- rst has the same effect as flush. In addition, rst clears the counters.
- flush does not clear the counters.
- Priority, highest first: rst, then flush, then push/pop.

## Timing
- Reset values (cycle after rst is sampled high):
  - in_ready = 1, out_valid = 0, out_data = 0, count = 0.
  - stall_cnt = 0, bubble_cnt = 0.
- Latency: an entry pushed at edge N appears on out_valid/out_data after edge N, i.e. one cycle. There is no bypass path.
- in_ready changes only after a clock edge. The upstream stage may sample it early in the cycle.
- Throughput: one entry per cycle at steady state when DEPTH ≥ 2 and out_ready = 1.
- Wrap-around: pointers wrap modulo DEPTH, including non-power-of-two DEPTH.
- Handshake stability: holding in_data stable while in_valid & ~in_ready is the upstream stage's duty. out_data holds stable while out_valid & ~out_ready, unless flush occurs.
- Reset or flush mid-transfer: the buffer is empty on the next cycle and accepts a new entry in that same cycle.

## Configuration
- Macro: PIPE_STAGE_BUF_PERF_EN.
- Defined:
  - stall_cnt increments in each cycle with out_valid & ~out_ready & ~flush.
  - bubble_cnt increments in each cycle with ~out_valid & out_ready.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared only by rst.
- Undefined: both counter outputs are tied to 0 and no counter registers are built.

## Test plan
- Reset then idle: rst high for 2 cycles, in_valid = 0 → out_valid = 0, out_data = 0, count = 0, in_ready = 1.
- Streaming, DEPTH=2: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 1 → out_data = 0x11, 0x22, 0x33 on the three following cycles, count stays 1.
- Backpressure, DEPTH=2: out_ready = 0, push 0xA, 0xB, offer 0xC → in_ready = 0 after the 2nd push and count = 2. Raise out_ready → outputs 0xA, 0xB, then 0xC, in order, with no loss.
- Flush with push and pop: count = 2, assert flush together with in_valid = 1 and out_ready = 1 → next cycle count = 0, out_valid = 0, out_data = 0, and the offered entry is absent.
- Wrap, DEPTH=3: 10 pushes of 1..10 with pop once every 2 cycles → pop order is exactly 1..10 and count never exceeds 3.
- PERF_EN: 5 cycles of out_valid & ~out_ready, then 4 empty cycles with out_ready = 1 → stall_cnt = 5, bubble_cnt = 4. A following flush leaves both counter values unchanged.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf_if
// Description : Handshake bundle between a pipeline stage buffer and its
//               upstream/downstream neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_buf_if #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic [31:0]      stall_cnt;
  logic [31:0]      bubble_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, stall_cnt, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, stall_cnt, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : DEPTH-entry elastic pipeline register with flush; optional
//               stall/bubble counters enabled by PIPE_STAGE_BUF_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pipe_stage_buf_if.slave  bus
);
  localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   c_FULL     = CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rp;
  logic [c_PTR_W-1:0] r_wp;
  logic [CNT_W-1:0]   r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Ready comes purely from registered occupancy: no out_ready -> in_ready path.
  assign w_in_ready  = (r_count < c_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= bus.in_data;
        r_wp        <= f_next(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_next(r_rp);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem[r_rp] : '0;
  assign bus.count     = r_count;

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Counters survive flush; only rst clears them. Both saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready && !bus.flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!w_out_valid && bus.out_ready && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
`else
  assign bus.stall_cnt  = 32'd0;
  assign bus.bubble_cnt = 32'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Scoreboard bench for pipe_stage_buf at DEPTH=2 and DEPTH=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;
  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fl_s = 1'b0;
  logic         iv_s = 1'b0;
  logic [W-1:0] id_s = '0;
  logic         or_s = 1'b0;
  bit           started = 1'b0;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.WIDTH(W), .DEPTH(2)) b2 ();
  pipe_stage_buf_if #(.WIDTH(W), .DEPTH(3)) b3 ();

  assign b2.flush = fl_s;  assign b2.in_valid = iv_s;
  assign b2.in_data = id_s; assign b2.out_ready = or_s;
  assign b3.flush = fl_s;  assign b3.in_valid = iv_s;
  assign b3.in_data = id_s; assign b3.out_ready = or_s;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each buffer is an ordered queue bounded by its depth.
  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];
  logic [31:0]  st2 = '0, bb2 = '0, st3 = '0, bb3 = '0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      q2.delete(); q3.delete();
      st2 <= '0; bb2 <= '0; st3 <= '0; bb3 <= '0;
    end else begin
      if (q2.size() != 0 && !or_s && !fl_s && st2 != 32'hFFFF_FFFF) st2 <= st2 + 1;
      if (q2.size() == 0 && or_s && bb2 != 32'hFFFF_FFFF)           bb2 <= bb2 + 1;
      if (q3.size() != 0 && !or_s && !fl_s && st3 != 32'hFFFF_FFFF) st3 <= st3 + 1;
      if (q3.size() == 0 && or_s && bb3 != 32'hFFFF_FFFF)           bb3 <= bb3 + 1;
      if (fl_s) begin
        q2.delete(); q3.delete();
      end else begin
        if (q2.size() != 0 && or_s) begin
          if (iv_s && q2.size() < 2) q2.push_back(id_s);
          void'(q2.pop_front());
        end else if (iv_s && q2.size() < 2) q2.push_back(id_s);
        if (q3.size() != 0 && or_s) begin
          if (iv_s && q3.size() < 3) q3.push_back(id_s);
          void'(q3.pop_front());
        end else if (iv_s && q3.size() < 3) q3.push_back(id_s);
      end
    end
  end

  // Monitors: compare every visible output against the model mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("d2.in_ready",  W'(b2.in_ready),  W'(q2.size() < 2));
      chk("d2.out_valid", W'(b2.out_valid), W'(q2.size() != 0));
      chk("d2.count",     W'(b2.count),     W'(q2.size()));
      chk("d2.out_data",  b2.out_data,      (q2.size() != 0) ? q2[0] : '0);
`ifdef PIPE_STAGE_BUF_PERF_EN
      chk("d2.stall_cnt",  W'(b2.stall_cnt),  W'(st2));
      chk("d2.bubble_cnt", W'(b2.bubble_cnt), W'(bb2));
`else
      chk("d2.stall_cnt",  W'(b2.stall_cnt),  '0);
      chk("d2.bubble_cnt", W'(b2.bubble_cnt), '0);
`endif
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("d3.in_ready",  W'(b3.in_ready),  W'(q3.size() < 3));
      chk("d3.out_valid", W'(b3.out_valid), W'(q3.size() != 0));
      chk("d3.count",     W'(b3.count),     W'(q3.size()));
      chk("d3.out_data",  b3.out_data,      (q3.size() != 0) ? q3[0] : '0);
`ifdef PIPE_STAGE_BUF_PERF_EN
      chk("d3.stall_cnt",  W'(b3.stall_cnt),  W'(st3));
      chk("d3.bubble_cnt", W'(b3.bubble_cnt), W'(bb3));
`endif
    end
  end

  task automatic step(input logic fl, input logic v, input logic [W-1:0] d, input logic r);
    fl_s = fl; iv_s = v; id_s = d; or_s = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int guard;
    logic acc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    // Streaming
    step(0, 1, W'(32'h11), 1);
    step(0, 1, W'(32'h22), 1);
    step(0, 1, W'(32'h33), 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Backpressure, then release with the third entry held until accepted
    step(0, 1, W'(32'hA), 0);
    step(0, 1, W'(32'hB), 0);
    step(0, 1, W'(32'hC), 0);
    step(0, 1, W'(32'hC), 1);
    step(0, 1, W'(32'hC), 1);
    repeat (4) step(0, 0, '0, 1);

    // Flush colliding with push and pop
    step(0, 1, W'(32'h1), 0);
    step(0, 1, W'(32'h2), 0);
    step(1, 1, W'(32'h3), 1);
    repeat (2) step(0, 0, '0, 1);

    // Wrap on DEPTH=3: values 1..10, pop every second cycle
    k = 1;
    guard = 0;
    while (k <= 10 && guard < 200) begin
      fl_s = 0; iv_s = 1; id_s = W'(k); or_s = guard[0];
      acc = b3.in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      guard++;
    end
    chk("wrap_budget", W'(k), W'(11));
    repeat (6) step(0, 0, '0, 1);

    // Performance counters: 5 stall cycles, 4 bubble cycles, then a flush
    rst = 1'b1;
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    rst = 1'b0;
    step(0, 1, W'(32'h5), 0);
    repeat (5) step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    repeat (4) step(0, 0, '0, 1);
    or_s = 1'b0;
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("perf_stall",  W'(b2.stall_cnt),  W'(5));
    chk("perf_bubble", W'(b2.bubble_cnt), W'(4));
`else
    chk("perf_stall",  W'(b2.stall_cnt),  '0);
    chk("perf_bubble", W'(b2.bubble_cnt), '0);
`endif
    step(1, 0, '0, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("perf_stall_flush",  W'(b2.stall_cnt),  W'(5));
    chk("perf_bubble_flush", W'(b2.bubble_cnt), W'(4));
`else
    chk("perf_stall_flush",  W'(b2.stall_cnt),  '0);
    chk("perf_bubble_flush", W'(b2.bubble_cnt), '0);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    repeat (4) step(0, 0, '0, 1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
`default_nettype wire
